ysyx_exec_core: RTL and testbench

- Single-cycle decode/register-file/ALU datapath slice of the NPC.
- Each cycle it takes one 32-bit RISC-V instruction, decodes it, reads rs1 (and rs2 when R-type is enabled), and computes the ALU result.
- It writes rd on the next rising clock edge.
- It flags ebreak and unsupported encodings to the surrounding CPU. PC and fetch live outside this block.

---
 rtl/exec_core_pkg.sv | 41 ++++
 rtl/exec_core_gpr.sv | 40 ++++
 rtl/ysyx_exec_core.sv | 124 ++++++++++++
 tb/tb_ysyx_exec_core.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/exec_core_pkg.sv
// Shared encodings and ALU-op enum for the NPC decode/regfile/ALU slice.
// Optional R-type support is selected with EXEC_CORE_RTYPE_EN.
package exec_core_pkg;

  localparam logic [6:0]  OP_IMM      = 7'b0010011;
  localparam logic [6:0]  OP          = 7'b0110011;
  localparam logic [6:0]  LUI         = 7'b0110111;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  // alt selects SUB over ADD and SRA over SRL; it is ignored for other funct3.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/exec_core_gpr.sv
// GPR file: x1..x31, combinational reads (no bypass), one write port, async clear.
// The rs2 port exists only when EXEC_CORE_RTYPE_EN is defined.
module exec_core_gpr
  import exec_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      rs1_addr,
  output logic [XLEN-1:0] rs1_data,
`ifdef EXEC_CORE_RTYPE_EN
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs2_data,
`endif
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  // Entry 0 is never written; reads of x0 are forced to zero regardless.
  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
`ifdef EXEC_CORE_RTYPE_EN
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
`endif

endmodule

// File: rtl/ysyx_exec_core.sv
// Single-cycle decode + GPR + ALU slice: OP-IMM, LUI, ebreak detection.
// Define EXEC_CORE_RTYPE_EN to add the register-register OP group.
module ysyx_exec_core
  import exec_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr,
  output logic            wen,
  output logic            ebreak,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_rdata
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [6:0]      f7_sr;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic            sll_ok;
  logic            sr_ok;
  logic            legal;
  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_out;
`ifdef EXEC_CORE_RTYPE_EN
  logic [XLEN-1:0] rs2_data;
`endif

  assign opcode  = inst[6:0];
  assign f3      = inst[14:12];
  assign f7      = inst[31:25];
  assign rd_addr = inst[11:7];
  assign imm_i   = XLEN'($signed(inst[31:20]));
  assign imm_u   = XLEN'($signed({inst[31:12], 12'b0}));

  // For RV64 inst[25] is part of shamt, so only the bits above it must be clear.
  assign f7_sr  = f7 & ~F7_ALT;
  assign sll_ok = (XLEN == 64) ? (f7[6:1] == 6'd0)    : (f7 == 7'd0);
  assign sr_ok  = (XLEN == 64) ? (f7_sr[6:1] == 6'd0) : (f7_sr == 7'd0);

  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    op_b   = imm_i;
    shamt  = inst[20 +: SHW];
    case (opcode)
      OP_IMM: begin
        alu_op = f3_to_op(f3, (f3 == F3_SR) && inst[30]);
        case (f3)
          F3_SLL:  legal = sll_ok;
          F3_SR:   legal = sr_ok;
          default: legal = 1'b1;
        endcase
      end
      LUI: begin
        legal  = 1'b1;
        alu_op = ALU_PASS_B;
        op_b   = imm_u;
      end
`ifdef EXEC_CORE_RTYPE_EN
      OP: begin
        op_b   = rs2_data;
        shamt  = rs2_data[SHW-1:0];
        alu_op = f3_to_op(f3, f7 == F7_ALT);
        legal  = (f7 == F7_BASE) ||
                 ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD:    alu_out = rs1_data + op_b;
      ALU_SUB:    alu_out = rs1_data - op_b;
      ALU_SLL:    alu_out = rs1_data << shamt;
      ALU_SLT:    alu_out = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
      ALU_SLTU:   alu_out = {{(XLEN-1){1'b0}}, (rs1_data < op_b)};
      ALU_XOR:    alu_out = rs1_data ^ op_b;
      ALU_SRL:    alu_out = rs1_data >> shamt;
      ALU_SRA:    alu_out = $signed(rs1_data) >>> shamt;
      ALU_OR:     alu_out = rs1_data | op_b;
      ALU_AND:    alu_out = rs1_data & op_b;
      ALU_PASS_B: alu_out = op_b;
      default:    alu_out = '0;
    endcase
  end

  // Every supported encoding writes rd, so legality alone gates the write.
  assign ebreak  = (inst == EBREAK_INST);
  assign illegal = !legal && !ebreak;
  assign wen     = legal && (rd_addr != 5'd0);
  assign result  = legal ? alu_out : '0;

  exec_core_gpr #(.XLEN(XLEN)) u_gpr (
    .clk      (clk),
    .rst      (rstn),
    .we       (wen),
    .waddr    (rd_addr),
    .wdata    (result),
    .rs1_addr (inst[19:15]),
    .rs1_data (rs1_data),
`ifdef EXEC_CORE_RTYPE_EN
    .rs2_addr (inst[24:20]),
    .rs2_data (rs2_data),
`endif
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_rdata)
  );

endmodule

// File: tb/tb_ysyx_exec_core.sv
// Directed bench for ysyx_exec_core: reset, OP-IMM/LUI, ebreak/illegal, mid-run reset, OP group.
module tb_ysyx_exec_core;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] inst;
  logic [31:0] result;
  logic [4:0]  rd_addr;
  logic        wen;
  logic        ebreak;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_exec_core #(.XLEN(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .inst      (inst),
    .result    (result),
    .rd_addr   (rd_addr),
    .wen       (wen),
    .ebreak    (ebreak),
    .illegal   (illegal),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Instruction changes on the falling edge; it is written on the next rising edge.
  task automatic apply(input logic [31:0] i);
    @(negedge clk);
    inst = i;
    #1;
  endtask

  task automatic peek(input logic [4:0] a);
    dbg_addr = a;
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    inst = 32'h0050_0093;
    dbg_addr = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_x1: got %h want %h", dbg_rdata, 32'd0); end
    checks++; if (result !== 32'd5) begin errors++; $display("FAIL reset_result: got %h want %h", result, 32'd5); end
    peek(5'd31);
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_x31: got %h want %h", dbg_rdata, 32'd0); end
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic test_addi;
    apply(32'h0050_0093);
    checks++; if (result !== 32'd5) begin errors++; $display("FAIL addi_x1_result: got %h want %h", result, 32'd5); end
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL addi_x1_wen: got %b want 1", wen); end
    checks++; if (rd_addr !== 5'd1) begin errors++; $display("FAIL addi_x1_rd: got %0d want 1", rd_addr); end
    apply(32'hFFF0_8113);
    peek(5'd1);
    checks++; if (dbg_rdata !== 32'd5) begin errors++; $display("FAIL dbg_x1: got %h want %h", dbg_rdata, 32'd5); end
    checks++; if (result !== 32'd4) begin errors++; $display("FAIL addi_x2_result: got %h want %h", result, 32'd4); end
    apply(enc_i(12'd7, 5'd1, 3'b000, 5'd0));
    peek(5'd2);
    checks++; if (dbg_rdata !== 32'd4) begin errors++; $display("FAIL dbg_x2: got %h want %h", dbg_rdata, 32'd4); end
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL addi_x0_wen: got %b want 0", wen); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL addi_x0_result: got %h want %h", result, 32'd12); end
    apply(enc_i(12'hFF8, 5'd0, 3'b000, 5'd3));
    peek(5'd0);
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL dbg_x0: got %h want %h", dbg_rdata, 32'd0); end
    checks++; if (result !== 32'hFFFF_FFF8) begin errors++; $display("FAIL addi_x3_result: got %h want %h", result, 32'hFFFF_FFF8); end
  endtask

  task automatic test_opimm;
    apply(enc_i(12'h401, 5'd3, 3'b101, 5'd4));
    checks++; if (result !== 32'hFFFF_FFFC) begin errors++; $display("FAIL srai: got %h want %h", result, 32'hFFFF_FFFC); end
    apply(enc_i(12'h01C, 5'd3, 3'b101, 5'd5));
    checks++; if (result !== 32'h0000_000F) begin errors++; $display("FAIL srli: got %h want %h", result, 32'h0000_000F); end
    apply(enc_i(12'hFFF, 5'd0, 3'b011, 5'd6));
    checks++; if (result !== 32'd1) begin errors++; $display("FAIL sltiu: got %h want %h", result, 32'd1); end
    apply(enc_i(12'h000, 5'd3, 3'b010, 5'd7));
    checks++; if (result !== 32'd1) begin errors++; $display("FAIL slti_true: got %h want %h", result, 32'd1); end
    apply(enc_i(12'hFF7, 5'd3, 3'b010, 5'd10));
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL slti_false: got %h want %h", result, 32'd0); end
    apply(enc_i(12'h003, 5'd1, 3'b001, 5'd11));
    checks++; if (result !== 32'd40) begin errors++; $display("FAIL slli: got %h want %h", result, 32'd40); end
    apply(enc_i(12'hFFF, 5'd3, 3'b100, 5'd12));
    checks++; if (result !== 32'd7) begin errors++; $display("FAIL xori: got %h want %h", result, 32'd7); end
    apply(enc_i(12'h0F0, 5'd1, 3'b110, 5'd13));
    checks++; if (result !== 32'h0000_00F5) begin errors++; $display("FAIL ori: got %h want %h", result, 32'h0000_00F5); end
  endtask

  task automatic test_lui;
    apply(32'h1234_5437);
    checks++; if (result !== 32'h1234_5000) begin errors++; $display("FAIL lui_x8: got %h want %h", result, 32'h1234_5000); end
    apply(32'h8000_0737);
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL lui_sign: got %h want %h", result, 32'h8000_0000); end
    apply(enc_i(12'h0FF, 5'd8, 3'b111, 5'd9));
    peek(5'd8);
    checks++; if (dbg_rdata !== 32'h1234_5000) begin errors++; $display("FAIL dbg_x8: got %h want %h", dbg_rdata, 32'h1234_5000); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL andi: got %h want %h", result, 32'd0); end
  endtask

  task automatic test_ebreak_illegal;
    apply(32'h0010_0073);
    checks++; if ({ebreak, wen, illegal} !== 3'b100) begin errors++; $display("FAIL ebreak_flags: got %b want 100", {ebreak, wen, illegal}); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL ebreak_result: got %h want %h", result, 32'd0); end
    apply(32'hFFFF_FFFF);
    peek(5'd1);
    checks++; if (dbg_rdata !== 32'd5) begin errors++; $display("FAIL ebreak_x1_kept: got %h want %h", dbg_rdata, 32'd5); end
    checks++; if ({ebreak, wen, illegal} !== 3'b001) begin errors++; $display("FAIL allones_flags: got %b want 001", {ebreak, wen, illegal}); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL allones_result: got %h want %h", result, 32'd0); end
    apply(enc_i(12'h020, 5'd1, 3'b001, 5'd15));
    peek(5'd31);
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL illegal_x31_kept: got %h want %h", dbg_rdata, 32'd0); end
    checks++; if ({wen, illegal} !== 2'b01) begin errors++; $display("FAIL slli_bit25: got %b want 01", {wen, illegal}); end
    apply(enc_i(12'h021, 5'd3, 3'b101, 5'd15));
    checks++; if ({wen, illegal} !== 2'b01) begin errors++; $display("FAIL srli_bit25: got %b want 01", {wen, illegal}); end
    apply(enc_i(12'h601, 5'd3, 3'b101, 5'd15));
    checks++; if ({wen, illegal} !== 2'b01) begin errors++; $display("FAIL srai_bit29: got %b want 01", {wen, illegal}); end
    apply(enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd20));
    peek(5'd15);
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL illegal_x15_kept: got %h want %h", dbg_rdata, 32'd0); end
    checks++; if ({wen, illegal, result} !== {2'b01, 32'd0}) begin errors++; $display("FAIL op_bad_funct7: got %b/%h want 01/0", {wen, illegal}, result); end
  endtask

  task automatic test_rtype;
    apply(32'h4020_84B3);
`ifdef EXEC_CORE_RTYPE_EN
    checks++; if (result !== 32'd1) begin errors++; $display("FAIL sub: got %h want %h", result, 32'd1); end
    checks++; if ({wen, illegal} !== 2'b10) begin errors++; $display("FAIL sub_flags: got %b want 10", {wen, illegal}); end
    apply(enc_r(7'b0000000, 5'd1, 5'd3, 3'b010, 5'd18));
    checks++; if (result !== 32'd1) begin errors++; $display("FAIL slt: got %h want %h", result, 32'd1); end
    apply(enc_r(7'b0100000, 5'd1, 5'd3, 3'b101, 5'd19));
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra: got %h want %h", result, 32'hFFFF_FFFF); end
    peek(5'd9);
    checks++; if (dbg_rdata !== 32'd1) begin errors++; $display("FAIL dbg_x9: got %h want %h", dbg_rdata, 32'd1); end
`else
    checks++; if ({wen, illegal} !== 2'b01) begin errors++; $display("FAIL sub_disabled: got %b want 01", {wen, illegal}); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL sub_disabled_result: got %h want %h", result, 32'd0); end
`endif
  endtask

  task automatic test_reset_mid;
    apply(enc_i(12'd9, 5'd0, 3'b000, 5'd16));
    @(posedge clk);
    #2;
    peek(5'd16);
    checks++; if (dbg_rdata !== 32'd9) begin errors++; $display("FAIL pre_reset_x16: got %h want %h", dbg_rdata, 32'd9); end
    rstn = 1'b1;
    #1;
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL async_clear_x16: got %h want %h", dbg_rdata, 32'd0); end
    peek(5'd1);
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL async_clear_x1: got %h want %h", dbg_rdata, 32'd0); end
    inst = enc_i(12'd3, 5'd1, 3'b000, 5'd17);
    #1;
    checks++; if (result !== 32'd3) begin errors++; $display("FAIL reset_operand: got %h want %h", result, 32'd3); end
    dbg_addr = 5'd17;
    @(posedge clk);
    #1;
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_no_write: got %h want %h", dbg_rdata, 32'd0); end
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (dbg_rdata !== 32'd3) begin errors++; $display("FAIL write_after_reset: got %h want %h", dbg_rdata, 32'd3); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_opimm;
    test_lui;
    test_ebreak_illegal;
    test_rtype;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
